// File: rtl/fp32_mul_pkg.sv
// Shared constants and types for the FP32 multiplier normalize/round stage.
// Class codes, flag bit positions and exponent helper constants live here.
package fp32_mul_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int          BIAS   = 127;

    localparam int unsigned PROD_W = 2 * MANT_W;
    localparam int unsigned FRAC_W = MANT_W - 1;
    // Two extra bits so the unbiased-sum exponent can go negative or past 255.
    localparam int unsigned E_W    = EXP_W + 2;

    localparam logic signed [E_W-1:0] BIAS_E  = E_W'(BIAS);
    localparam logic signed [E_W-1:0] EXP_SAT = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] EXP_INC = E_W'(1);
    localparam logic signed [E_W-1:0] EXP_MIN = '0;

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } cls_e;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp32_mul_norm_round_if.sv
// Valid/ready bus into and out of the normalize/round stage.
// master drives the input beat and out_ready; slave is the stage itself.
interface fp32_mul_norm_round_if;
    import fp32_mul_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_sign;
    logic [EXP_W-1:0]    in_exp_a;
    logic [EXP_W-1:0]    in_exp_b;
    logic [PROD_W-1:0]   in_sum;
    logic [PROD_W-1:0]   in_carry;
    logic [1:0]          in_cls;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_result;
    logic [3:0]          out_flags;

    modport master (
        output in_valid, in_sign, in_exp_a, in_exp_b, in_sum, in_carry, in_cls, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp_a, in_exp_b, in_sum, in_carry, in_cls, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational normalize, round-to-nearest-even, exponent range check and FP32 pack.
// Special classes bypass the arithmetic entirely.
module fp_round_rne
    import fp32_mul_pkg::*;
(
    input  logic                  sign_i,
    input  logic [1:0]            cls_i,
    input  logic [PROD_W-1:0]     prod_i,
    input  logic signed [E_W-1:0] exp_i,
    output logic [31:0]           result_o,
    output logic [3:0]            flags_o
);

    logic [FRAC_W-1:0]     mant_pre;
    logic [FRAC_W-1:0]     mant_rnd;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic                  carry;
    logic                  inexact;
    logic signed [E_W-1:0] exp_n;
    logic signed [E_W-1:0] exp_r;

    always_comb begin
        // Product of two normals is in [1,4): top bit picks the 1-bit shift.
        if (prod_i[PROD_W-1]) begin
            mant_pre = prod_i[PROD_W-2 -: FRAC_W];
            guard    = prod_i[PROD_W-2-FRAC_W];
            sticky   = |prod_i[PROD_W-3-FRAC_W:0];
            exp_n    = exp_i + EXP_INC;
        end else begin
            mant_pre = prod_i[PROD_W-3 -: FRAC_W];
            guard    = prod_i[PROD_W-3-FRAC_W];
            sticky   = |prod_i[PROD_W-4-FRAC_W:0];
            exp_n    = exp_i;
        end

        round_up          = guard & (sticky | mant_pre[0]);
        {carry, mant_rnd} = {1'b0, mant_pre} + {{FRAC_W{1'b0}}, round_up};
        exp_r             = carry ? exp_n + EXP_INC : exp_n;
        inexact           = guard | sticky;

        result_o = '0;
        flags_o  = '0;
        unique case (cls_e'(cls_i))
            CLS_NORM: begin
                if (exp_r >= EXP_SAT) begin
                    result_o                = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    flags_o[FLAG_OVERFLOW]  = 1'b1;
                    flags_o[FLAG_INEXACT]   = 1'b1;
                end else if (exp_r <= EXP_MIN) begin
                    // No subnormal support: flush to signed zero.
                    result_o                = {sign_i, {(31){1'b0}}};
                    flags_o[FLAG_UNDERFLOW] = 1'b1;
                    flags_o[FLAG_INEXACT]   = 1'b1;
                end else begin
                    result_o              = {sign_i, exp_r[EXP_W-1:0], mant_rnd};
                    flags_o[FLAG_INEXACT] = inexact;
                end
            end
            CLS_ZERO: result_o = {sign_i, {(31){1'b0}}};
            CLS_INF:  result_o = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            CLS_NAN: begin
                result_o              = QNAN;
                flags_o[FLAG_INVALID] = 1'b1;
            end
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/fp32_mul_norm_round.sv
// Two-stage valid/ready pipeline: stage 1 resolves the redundant product and exponent,
// stage 2 registers the rounded, packed FP32 result and flags.
module fp32_mul_norm_round
    import fp32_mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fp32_mul_norm_round_if.slave  bus
);

    logic                  s2_en;
    logic                  s1_en;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q,  s1_sign_d;
    logic [1:0]            s1_cls_q,   s1_cls_d;
    logic [PROD_W-1:0]     s1_p_q,     s1_p_d;
    logic signed [E_W-1:0] s1_e_q,     s1_e_d;

    logic                  out_valid_q,  out_valid_d;
    logic [31:0]           out_result_q, out_result_d;
    logic [3:0]            out_flags_q,  out_flags_d;

    logic [31:0]           rnd_result;
    logic [3:0]            rnd_flags;

    fp_round_rne u_round (
        .sign_i   (s1_sign_q),
        .cls_i    (s1_cls_q),
        .prod_i   (s1_p_q),
        .exp_i    (s1_e_q),
        .result_o (rnd_result),
        .flags_o  (rnd_flags)
    );

    always_comb begin
        s2_en = !out_valid_q | bus.out_ready;
        s1_en = !s1_valid_q | s2_en;

        s1_valid_d = s1_en ? bus.in_valid : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_cls_d   = s1_cls_q;
        s1_p_d     = s1_p_q;
        s1_e_d     = s1_e_q;
        if (s1_en && bus.in_valid) begin
            s1_sign_d = bus.in_sign;
            s1_cls_d  = bus.in_cls;
            s1_p_d    = bus.in_sum + bus.in_carry;
            s1_e_d    = signed'({2'b00, bus.in_exp_a}) + signed'({2'b00, bus.in_exp_b}) - BIAS_E;
        end

        // Output data only moves when a new beat lands, so it holds under backpressure.
        out_valid_d  = s2_en ? s1_valid_q : out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (s2_en && s1_valid_q) begin
            out_result_d = rnd_result;
            out_flags_d  = rnd_flags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_cls_q     <= '0;
            s1_p_q       <= '0;
            s1_e_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_cls_q     <= s1_cls_d;
            s1_p_q       <= s1_p_d;
            s1_e_q       <= s1_e_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign bus.in_ready   = s1_en;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp32_mul_norm_round.sv
// Directed bench for fp32_mul_norm_round: expected results are queued on input accept
// and compared in order as beats leave the pipeline.
module tb_fp32_mul_norm_round;
    import fp32_mul_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic tb_ready;
    bit   rand_ready = 1'b0;
    logic rnd_bit = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] prev_res;
    logic [3:0]  prev_flg;
    bit   prev_stall = 1'b0;

    always #5 clk = ~clk;

    fp32_mul_norm_round_if bus ();

    fp32_mul_norm_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
    assign bus.out_ready = rand_ready ? rnd_bit : tb_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard side: compare every beat leaving the pipe, and check hold under stall.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall && bus.out_valid) begin
                chk("hold_result", bus.out_result, prev_res);
                chk("hold_flags", {28'b0, bus.out_flags}, {28'b0, prev_flg});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.tag, "_res"}, bus.out_result, mon_e.res);
                    chk({mon_e.tag, "_flags"}, {28'b0, bus.out_flags}, {28'b0, mon_e.flg});
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.out_result;
            prev_flg   = bus.out_flags;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic s, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [47:0] sm, input logic [47:0] cy, input logic [1:0] cl,
                        input logic [31:0] er, input logic [3:0] ef, input string tag);
        int  n = 0;
        bit  done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp_a = ea;
        bus.in_exp_b = eb;
        bus.in_sum   = sm;
        bus.in_carry = cy;
        bus.in_cls   = cl;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{er, ef, tag});
                done = 1'b1;
            end else if (++n > 60) begin
                chk({tag, "_accept_timeout"}, {31'b0, bus.in_ready}, 32'd1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        tb_ready     = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sign  = 1'b0;
        bus.in_exp_a = '0;
        bus.in_exp_b = '0;
        bus.in_sum   = '0;
        bus.in_carry = '0;
        bus.in_cls   = '0;
        #1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_flags", {28'b0, bus.out_flags}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 1.0 * 1.0 with latency check
        send(0, 8'd127, 8'd127, 48'h400000000000, 48'h0, 2'b00, 32'h3F800000, 4'h0, "one");
        @(negedge clk);
        chk("lat_cycle1", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2", {31'b0, bus.out_valid}, 32'd1);
        drain("one");

        // Arithmetic and special classes, back to back
        send(0, 8'd127, 8'd127, 48'h800000000000, 48'h100000000000, 2'b00,
             32'h40100000, 4'h0, "one_p5_sq");
        send(0, 8'd127, 8'd127, 48'h400000400000, 48'h0, 2'b00, 32'h3F800000, 4'h1, "tie_even");
        send(0, 8'd127, 8'd127, 48'h400000C00000, 48'h0, 2'b00, 32'h3F800002, 4'h1, "tie_odd");
        send(0, 8'd127, 8'd127, 48'h7FFFFFC00000, 48'h0, 2'b00, 32'h40000000, 4'h1, "rnd_carry");
        send(0, 8'hFE, 8'hFE, 48'h400000000000, 48'h0, 2'b00, 32'h7F800000, 4'h5, "overflow");
        send(0, 8'hFE, 8'h7F, 48'h400000000000, 48'h0, 2'b00, 32'h7F000000, 4'h0, "max_exp");
        send(1, 8'h01, 8'h01, 48'h400000000000, 48'h0, 2'b00, 32'h80000000, 4'h3, "underflow");
        send(0, 8'h01, 8'h7F, 48'h400000000000, 48'h0, 2'b00, 32'h00800000, 4'h0, "min_exp");
        send(0, 8'h00, 8'h7F, 48'h400000000000, 48'h0, 2'b00, 32'h00000000, 4'h3, "exp_zero");
        send(0, 8'd127, 8'd127, 48'h400000000000, 48'h0, 2'b11, 32'h7FC00000, 4'h8, "nan");
        send(1, 8'd127, 8'd127, 48'h400000000000, 48'h0, 2'b01, 32'h80000000, 4'h0, "zero_neg");
        send(1, 8'd10, 8'd20, 48'h123456789ABC, 48'h0, 2'b10, 32'hFF800000, 4'h0, "inf_neg");
        drain("directed");

        // Backpressure: in_valid held high, downstream stalled for 6 cycles
        tb_ready = 1'b0;
        send(0, 8'd127, 8'd128, 48'h400000000000, 48'h0, 2'b00, 32'h40000000, 4'h0, "bp0");
        send(0, 8'd127, 8'd129, 48'h400000000000, 48'h0, 2'b00, 32'h40800000, 4'h0, "bp1");
        bus.in_valid = 1'b1;
        bus.in_exp_b = 8'd130;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_accepted", 32'(sb.size()), 32'd2);
            @(posedge clk);
            #1;
        end
        tb_ready = 1'b1;
        send(0, 8'd127, 8'd130, 48'h400000000000, 48'h0, 2'b00, 32'h41000000, 4'h0, "bp2");
        send(0, 8'd127, 8'd131, 48'h400000000000, 48'h0, 2'b00, 32'h41800000, 4'h0, "bp3");
        drain("bp");

        // Streaming with random downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(0, 8'd127, 8'(100 + i), 48'h400000000000 + (48'(i) << 23), 48'(i) << 23,
                 2'b00, {1'b0, 8'(100 + i), 23'(2 * i)}, 4'h0, "stream");
        end
        drain("stream");
        rand_ready = 1'b0;

        // Reset with both stages full
        tb_ready = 1'b0;
        send(0, 8'd127, 8'd127, 48'h400000000000, 48'h0, 2'b00, 32'h3F800000, 4'h0, "drop0");
        send(0, 8'd127, 8'd128, 48'h400000000000, 48'h0, 2'b00, 32'h40000000, 4'h0, "drop1");
        chk("pre_rst_out_valid", {31'b0, bus.out_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_rst_out_result", bus.out_result, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        tb_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(0, 8'd127, 8'd127, 48'h400000000000, 48'h0, 2'b00, 32'h3F800000, 4'h0, "post_rst");
        drain("post_rst");
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp32_mul_norm_round.md
Name: fp32_mul_norm_round

Overview:
Downstream stage of wallace_tree_24x24 in the FP32 multiplier datapath. Takes the 48-bit redundant product (sum/carry vectors) of two 24-bit mantissas, with the operand exponents, sign and special-class code. Performs the carry-propagate add, 1-bit normalization, round-to-nearest-even, exponent adjust and overflow/underflow handling. Emits a packed IEEE-754 single-precision result through a 2-stage valid/ready pipeline.

Parameters:
MANT_W, 24, mantissa width including hidden bit; product width is 2*MANT_W.
EXP_W, 8, exponent field width.
BIAS, 127, exponent bias.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept input this cycle
in_sign  in  1  result sign (sign_a XOR sign_b, computed upstream)
in_exp_a  in  8  biased exponent of operand A
in_exp_b  in  8  biased exponent of operand B
in_sum  in  48  sum vector from compressor tree
in_carry  in  48  carry vector from compressor tree (already weight-aligned)
in_cls  in  2  special class: 00 normal, 01 zero, 10 inf, 11 nan (upstream maps inf*0 to nan)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  32  packed FP32 result
out_flags  out  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact

Behaviour:
- Reset (rst=0, async): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0. All in-flight beats dropped. in_ready=1 from the first cycle after reset release.
- Handshake: transfer on valid&ready at each interface.
  - s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en (combinational, no input-to-output combinational path on data).
- Latency: 2 cycles from input accept to out_valid when out_ready=1. Throughput: 1 beat/cycle.
- Ordering: strict in-order.
- Backpressure: out_result/out_flags held stable while out_valid & !out_ready. No beat lost or duplicated.
- Stage 1 (registered):
  - p = (in_sum + in_carry) mod 2^48.
  - e = in_exp_a + in_exp_b - BIAS, as signed 10-bit.
  - sign and cls registered alongside.
- Stage 2 (registered output):
  - Normal class: p lies in [2^46, 2^48).
  - If p[47]=1: mant=p[46:24], guard=p[23], sticky=|p[22:0], e=e+1.
  - Else: mant=p[45:23], guard=p[22], sticky=|p[21:0].
  - RNE: increment mant if guard & (sticky | mant[0]).
  - If the increment carries out of mant: mant=0, e=e+1.
  - inexact = guard | sticky.
  - If e >= 255: result {sign, 0xFF, 0}, set overflow and inexact.
  - If e <= 0: result {sign, 0x00, 0} (flush-to-zero, no subnormals), set underflow and inexact.
  - Otherwise: result {sign, e[7:0], mant}.
- Special classes override arithmetic; p is ignored.
  - zero: {sign, 31'b0}, flags 0.
  - inf: {sign, 0xFF, 0}, flags 0.
  - nan: 0x7FC00000, invalid=1.
- Simultaneous accept and emit in one cycle with all stages full is legal and is the full-throughput case.

Decomposition:
- Package fp32_mul_pkg holds: BIAS, EXP_W, MANT_W, class codes (CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN), QNAN constant 32'h7FC00000, flag bit indices.
- One combinational sub-module, fp_round_rne: normalize, round, exponent adjust, pack, flags. It is instantiated in stage 2. Pipeline registers and handshake stay in the top.

Test Plan:
- 1.0*1.0: exps 127/127, sum=0x400000000000, carry=0, cls=00 → out_result 0x3F800000, flags 0, out_valid exactly 2 cycles after accept.
- 1.5*1.5 split redundantly: sum=0x800000000000, carry=0x100000000000, exps 127/127 → 0x40100000 (p[47] normalization path), flags 0.
- RNE ties, exps 127/127:
  - p=0x400000400000 → 0x3F800000, flags 0x1 (tie, even, round down).
  - p=0x400000C00000 → 0x3F800002, flags 0x1 (tie, odd, round up).
- Range limits:
  - exps 0xFE/0xFE, p=0x400000000000 → 0x7F800000, flags 0x5.
  - exps 0x01/0x01 → 0x00000000, flags 0x3.
  - cls=11 → 0x7FC00000, flags 0x8.
  - cls=01 with sign=1 → 0x80000000.
- Backpressure: out_ready=0 for 6 cycles while in_valid=1 continuously → exactly 2 beats accepted, then in_ready=0 and out_result held. On out_ready=1, all beats are emitted in order with no loss or duplication.
- Reset mid-operation: rst=0 for 1 cycle with both stages full → out_valid=0 immediately (async), nothing emitted for the dropped beats, and a fresh 1.0*1.0 afterwards returns 0x3F800000.
